// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after WIDTH iterations and holds the
// pipeline with stallreq until the single-cycle ready pulse.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  // {partial remainder (WIDTH+1 bits), dividend/quotient (WIDTH bits)}
  logic [2*WIDTH:0]   work, work_nxt, shifted;
  logic [WIDTH-1:0]   divisor;
  logic               quo_neg, rem_neg;
  logic               go, last;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign go   = start & ~flush;
  assign last = (cnt == CW'(WIDTH - 1));

  // Signed mode divides magnitudes; the most negative value maps onto
  // itself, which as an unsigned magnitude is exactly right.
  assign mag1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign mag2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // One restoring step: shift, trial-subtract, keep difference if non-negative.
  always_comb begin
    shifted  = {work[2*WIDTH-1:0], 1'b0};
    diff     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
    work_nxt = shifted;
    if (!diff[WIDTH+1]) begin
      work_nxt[2*WIDTH:WIDTH] = diff[WIDTH:0];
      work_nxt[0]             = 1'b1;
    end
  end

  // Sign fixups applied to the final step's magnitudes.
  always_comb begin
    quo_fix = quo_neg ? -work_nxt[WIDTH-1:0]       : work_nxt[WIDTH-1:0];
    rem_fix = rem_neg ? -work_nxt[2*WIDTH-1:WIDTH] : work_nxt[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, ready and stallreq; stallreq never looks at operand values.
  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          stallreq  = 1'b1;
          state_nxt = (opdata2 == '0) ? ZERO : BUSY;
        end
      end
      ZERO: begin
        stallreq  = 1'b1;
        state_nxt = DONE;
      end
      BUSY: begin
        stallreq = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath: latch operands on start, iterate in BUSY, load result at the end.
  // A flush freezes everything so an aborted divide never touches result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      work    <= '0;
      divisor <= '0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      result  <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (start && opdata2 != '0) begin
            work    <= {{(WIDTH+1){1'b0}}, mag1};
            divisor <= mag2;
            quo_neg <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            rem_neg <= signed_div & opdata1[WIDTH-1];
            cnt     <= '0;
          end
        end
        ZERO: result <= '0;
        BUSY: begin
          work <= work_nxt;
          cnt  <= cnt + 1'b1;
          if (last) result <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed + random divides against an arithmetic reference.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst, flush, start, signed_div;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready, stallreq;
  int          total = 0;
  int          bad   = 0;

  ex_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start),
    .signed_div(signed_div), .opdata1(opdata1), .opdata2(opdata2),
    .result(result), .ready(ready), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, C-style truncating division.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y, q, r;
    if (b == 0) return 64'd0;
    if (s) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = {32'h0, a};
      y = {32'h0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Starts a divide at the next negedge (cycle 0) and returns during the
  // ready cycle with start still high. Scrambles inputs mid-BUSY.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    int          cyc, stall_err, lat;
    logic [63:0] exp;
    exp = model(a, b, s);
    lat = (b == 0) ? 2 : 33;
    @(negedge clk);
    start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
    cyc = 0; stall_err = 0;
    forever begin
      #1;
      if (ready || cyc >= 60) break;
      if (stallreq !== 1'b1) stall_err++;
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = ~s;
      end
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_stall_busy"}, stall_err, 0);
    chk({tag, "_stall_done"}, stallreq, 0);
    chk({tag, "_res"}, result, exp);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("idle_rdy", ready, 0);
    chk("idle_stall", stallreq, 0);
  endtask

  initial begin
    logic [63:0] prev;
    logic        rdy_seen;
    logic [31:0] a, b;
    logic        s;
    rst = 1'b1; flush = 1'b0; start = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_res", result, 0);
    chk("rst_rdy", ready, 0);
    chk("rst_stall", stallreq, 0);

    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    chk("tp_100_7", result, {32'd2, 32'd14});
    idle_cycle();
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, "div_m7_2");
    chk("tp_m7_2", result, {32'hFFFFFFFF, 32'hFFFFFFFD});
    idle_cycle();
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, "div_7_m2");
    chk("tp_7_m2", result, {32'h00000001, 32'hFFFFFFFD});
    idle_cycle();
    run_div(32'd5, 32'd0, 1'b0, "divu_5_0");
    chk("tp_5_0", result, 64'd0);
    idle_cycle();
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");
    chk("tp_ovf", result, {32'h0, 32'h80000000});
    idle_cycle();
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, "divu_max_1");
    chk("tp_max_1", result, {32'h0, 32'hFFFFFFFF});
    idle_cycle();

    // Flush in cycle 10 of DIVU 1000/3; new divide starts in cycle 12.
    prev = result;
    rdy_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    if (ready) rdy_seen = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_stall", stallreq, 0);
    chk("flush_no_rdy", rdy_seen | ready, 0);
    chk("flush_res_held", result, prev);
    run_div(32'd9, 32'd4, 1'b0, "after_flush");
    chk("tp_9_4", result, {32'd1, 32'd2});
    idle_cycle();

    // Flush coincident with start in IDLE: nothing starts.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; opdata1 = 32'd40; opdata2 = 32'd3;
    #1;
    chk("flush_start_stall", stallreq, 0);
    idle_cycle();

    // Back-to-back: new operands presented in the DONE cycle, start held.
    run_div(32'd77, 32'd8, 1'b0, "b2b_first");
    opdata1 = 32'd50; opdata2 = 32'd5; signed_div = 1'b0;
    run_div(32'd50, 32'd5, 1'b0, "b2b_second");
    chk("tp_50_5", result, {32'd0, 32'd10});
    idle_cycle();

    // Reset mid-division, then a clean restart.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b1; opdata1 = 32'hFFFF0000; opdata2 = 32'd3;
    repeat (8) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_res", result, 0);
    chk("midrst_stall", stallreq, 0);
    chk("midrst_rdy", ready, 0);
    run_div(32'd123456, 32'd321, 1'b0, "post_rst");
    idle_cycle();

    // Random mix of signed/unsigned, small and zero divisors.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 20);
        4:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      s = $urandom_range(0, 1);
      run_div(a, b, s, "rand");
      idle_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
